// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared video pipeline constants: filter codes, code width, vsync polarity
package video_pkg;

  localparam int FILTER_W = 2;

  typedef enum logic [FILTER_W-1:0] {
    SEPIA  = 2'd0,
    INVERT = 2'd1,
    GRAY   = 2'd2,
    THRESH = 2'd3
  } filter_code_e;

  localparam logic VSYNC_ACTIVE = 1'b1;

  // Step to the next filter code, wrapping after the last implemented filter.
  function automatic logic [FILTER_W-1:0] next_filter(input logic [FILTER_W-1:0] code,
                                                      input int num_filters);
    return (int'(code) >= num_filters - 1) ? SEPIA : code + 1'b1;
  endfunction

endpackage

// File: rtl/edge_detect_rise.sv
// rtl/edge_detect_rise.sv - 1-bit rising-edge detector, combinational pulse in the first high cycle
module edge_detect_rise (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/filter_frame_ctrl.sv
// rtl/filter_frame_ctrl.sv - frame-synchronous filter select/bypass controller
// Auto-cycle mode is built only when FILTER_FRAME_CTRL_AUTO_EN is defined.
module filter_frame_ctrl
  import video_pkg::*;
#(
  parameter int NUM_FILTERS     = 4,
  parameter int FRAMES_PER_STEP = 60,
  parameter int CNT_W           = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                filters_en,
  input  logic [3:0]          sel_pulse,
  input  logic                auto_toggle,
  input  logic                vsync,
  output logic [FILTER_W-1:0] filter,
  output logic                bypass,
  output logic                pending,
  output logic                auto_active
);

  logic                fb;
  logic                sel_valid;
  logic [FILTER_W-1:0] sel_code;
  logic [FILTER_W-1:0] pend_filter;
  logic                pend_bypass;
  logic                pend_auto;
  logic [FILTER_W-1:0] pf_n;
  logic                pb_n;
  logic                pa_n;
  logic                step;
  logic [FILTER_W-1:0] adv_filter;

  edge_detect_rise u_fb (
    .clk  (clk),
    .rst  (rst),
    .d    (vsync == VSYNC_ACTIVE),
    .rise (fb)
  );

  // Descending scan so the lowest implemented set bit is the one that sticks.
  always_comb begin
    sel_valid = 1'b0;
    sel_code  = SEPIA;
    for (int i = NUM_FILTERS - 1; i >= 0; i--) begin
      if (sel_pulse[i]) begin
        sel_valid = 1'b1;
        sel_code  = FILTER_W'(i);
      end
    end
  end

  assign pf_n       = sel_valid ? sel_code : pend_filter;
  assign pb_n       = ~filters_en;
  assign adv_filter = next_filter(pf_n, NUM_FILTERS);

`ifdef FILTER_FRAME_CTRL_AUTO_EN
  logic [CNT_W-1:0] frame_cnt;

  assign pa_n = sel_valid ? 1'b0 : (pend_auto ^ auto_toggle);
  // Advance only in unbypassed auto mode that is not being cancelled at this boundary.
  assign step = fb & auto_active & ~bypass & pa_n &
                (frame_cnt == CNT_W'(FRAMES_PER_STEP - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_auto   <= 1'b0;
      auto_active <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      pend_auto <= pa_n;
      if (fb) begin
        auto_active <= pa_n;
        if (!auto_active && pa_n)
          frame_cnt <= '0;
        else if (auto_active && !bypass && pa_n)
          frame_cnt <= step ? '0 : frame_cnt + 1'b1;
      end
    end
  end
`else
  logic [CNT_W-1:0] unused_cfg;

  assign unused_cfg  = CNT_W'(FRAMES_PER_STEP) ^ {CNT_W{auto_toggle}};
  assign pa_n        = 1'b0;
  assign pend_auto   = 1'b0;
  assign auto_active = 1'b0;
  assign step        = 1'b0;
`endif

  // Requests landing in the boundary cycle are committed by that same boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_filter <= SEPIA;
      pend_bypass <= 1'b1;
      filter      <= SEPIA;
      bypass      <= 1'b1;
    end else begin
      pend_filter <= step ? adv_filter : pf_n;
      pend_bypass <= pb_n;
      if (fb) begin
        filter <= step ? adv_filter : pf_n;
        bypass <= pb_n;
      end
    end
  end

  assign pending = (pend_filter != filter) | (pend_bypass != bypass) | (pend_auto != auto_active);

endmodule
